// File: rtl/dcache_responder_if.sv
// dcache_responder_if: core data-port and backing-memory signals of the
// data-cache responder. The slave modport is the responder's view; the master
// modport is the view of the core/memory environment around it.
interface dcache_responder_if;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rnw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  dcache_addr, dcache_we, dcache_re, dcache_din,
    output dcache_dout, stall,
    output mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output dcache_addr, dcache_we, dcache_re, dcache_din,
    input  dcache_dout, stall,
    input  mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, one-word-per-line, write-through /
// no-write-allocate data cache in front of a valid/ready backing memory.
// Hits return in one cycle; misses and writes stall the core until done.
// Optional: define DCACHE_WBUF_EN for a one-entry background write buffer
// (writes no longer stall unless the buffer is already occupied).
module dcache_responder #(
  parameter int IDX_BITS = 6
) (
  input  logic              clk,
  input  logic              reset,
  dcache_responder_if.slave bus
);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int LINES    = 1 << IDX_BITS;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DRAIN} state_t;

  state_t              state;
  logic [LINES-1:0]    line_vld;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic        stall_q;
  logic [31:0] dout_q;
  logic        req_vld_q;
  logic        req_rnw_q;
  logic [29:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_wmask_q;
  logic [29:0] pend_addr;     // word address captured when the core request is sampled

`ifdef DCACHE_WBUF_EN
  // The buffered write lives in the req_* registers; wb_vld marks it pending.
  logic        wb_vld;
  logic        pend_rd;
  logic [31:0] pend_wdata;
  logic [3:0]  pend_wmask;
  logic        wb_free;
`endif

  logic [IDX_BITS-1:0] in_idx;
  logic [TAG_BITS-1:0] in_tag;
  logic [29:0]         in_addr;
  logic                hit, wr_req, rd_req, req_acc, fill;
  logic [31:0]         merged;
  logic                arr_we;
  logic [IDX_BITS-1:0] arr_idx;
  logic [TAG_BITS-1:0] arr_tag;
  logic [31:0]         arr_data;
  logic                unused_addr_lsb;

  assign in_addr = bus.dcache_addr[31:2];
  assign in_idx  = bus.dcache_addr[IDX_BITS+1:2];
  assign in_tag  = bus.dcache_addr[31:IDX_BITS+2];
  assign unused_addr_lsb = ^bus.dcache_addr[1:0];

  // Core requests are only taken in IDLE, which is exactly when stall is low.
  assign hit     = line_vld[in_idx] && (tag_mem[in_idx] == in_tag);
  assign wr_req  = (state == IDLE) && (bus.dcache_we != 4'b0000);
  assign rd_req  = (state == IDLE) && (bus.dcache_we == 4'b0000) && bus.dcache_re;
  assign req_acc = req_vld_q && bus.mem_req_ready;
  assign fill    = (state == RD_WAIT) && bus.mem_resp_valid;
`ifdef DCACHE_WBUF_EN
  // A buffer being accepted this cycle counts as free, so no dead cycle.
  assign wb_free = !wb_vld || req_acc;
`endif

  // Byte-merge of the write data into the currently stored line word.
  always_comb begin
    merged = data_mem[in_idx];
    for (int b = 0; b < 4; b++)
      if (bus.dcache_we[b]) merged[8*b +: 8] = bus.dcache_din[8*b +: 8];
  end

  // Line array write port: refill from memory, or write-hit merge.
  always_comb begin
    arr_we   = 1'b0;
    arr_idx  = in_idx;
    arr_tag  = in_tag;
    arr_data = merged;
    if (fill) begin
      arr_we   = 1'b1;
      arr_idx  = pend_addr[IDX_BITS-1:0];
      arr_tag  = pend_addr[29:IDX_BITS];
      arr_data = bus.mem_resp_data;
    end else if (wr_req && hit) begin
      arr_we   = 1'b1;
    end
  end

  // Tag/data storage; only the valid bits need reset.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[arr_idx]  <= arr_tag;
      data_mem[arr_idx] <= arr_data;
    end
  end

  // Control FSM with registered stall, read data and backing request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      line_vld    <= '0;
      stall_q     <= 1'b0;
      dout_q      <= '0;
      req_vld_q   <= 1'b0;
      req_rnw_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      pend_addr   <= '0;
`ifdef DCACHE_WBUF_EN
      wb_vld      <= 1'b0;
      pend_rd     <= 1'b0;
      pend_wdata  <= '0;
      pend_wmask  <= '0;
`endif
    end else begin
      if (fill) line_vld[arr_idx] <= 1'b1;
      case (state)
        IDLE: begin
`ifdef DCACHE_WBUF_EN
          if (req_acc) begin
            req_vld_q <= 1'b0;
            wb_vld    <= 1'b0;
          end
          if (wr_req) begin
            if (wb_free) begin
              wb_vld      <= 1'b1;
              req_vld_q   <= 1'b1;
              req_rnw_q   <= 1'b0;
              req_addr_q  <= in_addr;
              req_wdata_q <= bus.dcache_din;
              req_wmask_q <= bus.dcache_we;
            end else begin
              pend_rd    <= 1'b0;
              pend_addr  <= in_addr;
              pend_wdata <= bus.dcache_din;
              pend_wmask <= bus.dcache_we;
              stall_q    <= 1'b1;
              state      <= DRAIN;
            end
          end else if (rd_req) begin
            if (hit) begin
              dout_q <= data_mem[in_idx];
            end else begin
              pend_addr <= in_addr;
              stall_q   <= 1'b1;
              if (wb_free) begin
                req_vld_q  <= 1'b1;
                req_rnw_q  <= 1'b1;
                req_addr_q <= in_addr;
                state      <= RD_REQ;
              end else begin
                pend_rd <= 1'b1;
                state   <= DRAIN;
              end
            end
          end
`else
          if (wr_req) begin
            req_vld_q   <= 1'b1;
            req_rnw_q   <= 1'b0;
            req_addr_q  <= in_addr;
            req_wdata_q <= bus.dcache_din;
            req_wmask_q <= bus.dcache_we;
            stall_q     <= 1'b1;
            state       <= WR_REQ;
          end else if (rd_req) begin
            if (hit) begin
              dout_q <= data_mem[in_idx];
            end else begin
              pend_addr  <= in_addr;
              stall_q    <= 1'b1;
              req_vld_q  <= 1'b1;
              req_rnw_q  <= 1'b1;
              req_addr_q <= in_addr;
              state      <= RD_REQ;
            end
          end
`endif
        end
        RD_REQ: if (req_acc) begin
          req_vld_q <= 1'b0;
          state     <= RD_WAIT;
        end
        RD_WAIT: if (fill) begin
          dout_q  <= bus.mem_resp_data;
          stall_q <= 1'b0;
          state   <= IDLE;
        end
        WR_REQ: if (req_acc) begin
          req_vld_q <= 1'b0;
          stall_q   <= 1'b0;
          state     <= IDLE;
        end
`ifdef DCACHE_WBUF_EN
        // Old buffer entry accepted: issue the held request right behind it.
        DRAIN: if (req_acc) begin
          if (pend_rd) begin
            wb_vld     <= 1'b0;
            req_rnw_q  <= 1'b1;
            req_addr_q <= pend_addr;
            state      <= RD_REQ;
          end else begin
            req_rnw_q   <= 1'b0;
            req_addr_q  <= pend_addr;
            req_wdata_q <= pend_wdata;
            req_wmask_q <= pend_wmask;
            stall_q     <= 1'b0;
            state       <= IDLE;
          end
        end
`endif
        default: begin
          req_vld_q <= 1'b0;
          stall_q   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.dcache_dout   = dout_q;
  assign bus.stall         = stall_q;
  assign bus.mem_req_valid = req_vld_q;
  assign bus.mem_req_rnw   = req_rnw_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: randomized bench for dcache_responder. A word-level
// memory image plus a line-occupancy table predict read data and hit/miss;
// a queue of expected backing requests checks order and contents.
module tb_dcache_responder;
  localparam int TMO = 200;
`ifdef DCACHE_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_responder_if bus();
  dcache_responder #(.IDX_BITS(6)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  typedef struct packed {
    logic        rnw;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  mreq_t       exp_q[$];
  mreq_t       acc_log[$];
  int          tests = 0, fails = 0;
  logic [31:0] bmem [logic [29:0]];   // backing memory contents
  logic [31:0] rmem [logic [29:0]];   // architectural view the core expects
  bit          mvld [64];
  logic [23:0] mtag [64];
  bit          rdy_force_low = 1'b0;
  int          rsp_fixed = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_data = '0;
  int          acc_cnt = 0, resp_seen = 0;

  function automatic logic [31:0] init_val(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [31:0] bval(input logic [29:0] a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] rval(input logic [29:0] a);
    return rmem.exists(a) ? rmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Backing memory: random ready, scoreboard check on every accepted request,
  // one read response per accepted read after a short delay.
  initial begin
    mreq_t got, e;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = rsp_data;
          resp_seen++;
        end
      end
      bus.mem_req_ready = !rdy_force_low && ($urandom_range(0, 99) < 60);
      if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
        got = '{bus.mem_req_rnw, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask};
        acc_cnt++;
        acc_log.push_back(got);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL mem_req_unexpected got rnw=%0d addr=%h", got.rnw, got.addr);
        end else begin
          e = exp_q.pop_front();
          if (got.rnw !== e.rnw || got.addr !== e.addr ||
              (!e.rnw && (got.wdata !== e.wdata || got.wmask !== e.wmask))) begin
            fails++;
            $display("FAIL mem_req got rnw=%0d addr=%h wd=%h wm=%b required rnw=%0d addr=%h wd=%h wm=%b",
                     got.rnw, got.addr, got.wdata, got.wmask, e.rnw, e.addr, e.wdata, e.wmask);
          end
        end
        if (got.rnw) begin
          rsp_data = bval(got.addr);
          rsp_cnt  = (rsp_fixed > 0) ? rsp_fixed : $urandom_range(1, 3);
        end else begin
          bmem[got.addr] = bmerge(bval(got.addr), got.wdata, got.wmask);
        end
      end
    end
  end

  // Present a request at a negedge, hold it until sampled, then withdraw it.
  task automatic core_req(input bit wr, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] d, output int pre);
    bus.dcache_addr = a;
    bus.dcache_re   = !wr;
    bus.dcache_we   = wr ? m : 4'b0000;
    bus.dcache_din  = d;
    pre = 0;
    while (bus.stall && pre < TMO) begin @(negedge clk); pre++; end
    if (pre >= TMO) begin
      tests++; fails++;
      $display("FAIL accept_timeout addr=%h", a);
    end
    @(negedge clk);
    bus.dcache_re = 1'b0;
    bus.dcache_we = 4'b0000;
  endtask

  // Count stalled cycles; scribble the core inputs meanwhile (must be ignored).
  task automatic wait_stall_low(output int n);
    n = 0;
    while (bus.stall && n < TMO) begin
      bus.dcache_addr = $urandom;
      bus.dcache_din  = $urandom;
      bus.dcache_we   = 4'($urandom);
      bus.dcache_re   = 1'($urandom);
      @(negedge clk);
      n++;
    end
    bus.dcache_re = 1'b0;
    bus.dcache_we = 4'b0000;
    if (n >= TMO) begin
      tests++; fails++;
      $display("FAIL stall_timeout stall stuck high");
    end
  endtask

  task automatic do_read(input logic [31:0] a, output int n);
    logic [29:0] w;
    bit exp_hit;
    int pre;
    w = a[31:2];
    exp_hit = mvld[w[5:0]] && (mtag[w[5:0]] == w[29:6]);
    if (!exp_hit) exp_q.push_back('{1'b1, w, 32'h0, 4'h0});
    core_req(1'b0, a, 4'h0, 32'h0, pre);
    wait_stall_low(n);
    tests++;
    if ((n == 0) !== exp_hit) begin
      fails++;
      $display("FAIL rd_hit addr=%h stall_cycles=%0d required_hit=%0d", a, n, exp_hit);
    end
    tests++;
    if (bus.dcache_dout !== rval(w)) begin
      fails++;
      $display("FAIL rd_data addr=%h got=%h required=%h", a, bus.dcache_dout, rval(w));
    end
    mvld[w[5:0]] = 1'b1;
    mtag[w[5:0]] = w[29:6];
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, output int n);
    logic [29:0] w;
    int pre;
    w = a[31:2];
    rmem[w] = bmerge(rval(w), d, m);
    exp_q.push_back('{1'b0, w, d, m});
    core_req(1'b1, a, m, d, pre);
    wait_stall_low(n);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (bus.stall !== 1'b0 || bus.dcache_dout !== 32'h0 || bus.mem_req_valid !== 1'b0 ||
        bus.mem_req_rnw !== 1'b0 || bus.mem_req_addr !== 30'h0 || bus.mem_req_wdata !== 32'h0 ||
        bus.mem_req_wmask !== 4'h0) begin
      fails++;
      $display("FAIL reset_state stall=%b dout=%h vld=%b rnw=%b addr=%h required all zero",
               bus.stall, bus.dcache_dout, bus.mem_req_valid, bus.mem_req_rnw, bus.mem_req_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_midmiss_reset();
    int n, pre, w0, a0, r0;
    do_read(32'h140, n);
    rsp_fixed = 12;
    exp_q.push_back('{1'b1, 30'h0C0, 32'h0, 4'h0});
    a0 = acc_cnt;
    core_req(1'b0, 32'h300, 4'h0, 32'h0, pre);
    w0 = 0;
    while (acc_cnt == a0 && w0 < TMO) begin @(negedge clk); w0++; end
    tests++;
    if (acc_cnt == a0) begin fails++; $display("FAIL midmiss_accept no read request seen"); end
    repeat (2) @(negedge clk);
    r0 = resp_seen;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.stall !== 1'b0 || bus.dcache_dout !== 32'h0 || bus.mem_req_valid !== 1'b0 ||
        bus.mem_req_addr !== 30'h0) begin
      fails++;
      $display("FAIL midmiss_in_reset stall=%b dout=%h vld=%b addr=%h required 0", bus.stall,
               bus.dcache_dout, bus.mem_req_valid, bus.mem_req_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    w0 = 0;
    while (resp_seen == r0 && w0 < TMO) begin @(negedge clk); w0++; end
    repeat (2) @(negedge clk);
    tests++;
    if (bus.stall !== 1'b0 || bus.dcache_dout !== 32'h0) begin
      fails++;
      $display("FAIL late_resp stall=%b dout=%h required stall=0 dout=0", bus.stall, bus.dcache_dout);
    end
    for (int i = 0; i < 64; i++) mvld[i] = 1'b0;
    rsp_fixed = 0;
    do_read(32'h140, n);   // model now expects a miss: line must have been invalidated
    do_read(32'h300, n);
  endtask

  task automatic test_cold_read();
    int n, a0;
    bmem[30'h40] = 32'hDEADBEEF;
    rmem[30'h40] = 32'hDEADBEEF;
    do_read(32'h100, n);
    tests++;
    if (bus.dcache_dout !== 32'hDEADBEEF || n == 0) begin
      fails++;
      $display("FAIL cold_read dout=%h stall_cycles=%0d required DEADBEEF with stall", bus.dcache_dout, n);
    end
    a0 = acc_cnt;
    do_read(32'h100, n);
    repeat (3) @(negedge clk);
    tests++;
    if (n != 0 || acc_cnt != a0) begin
      fails++;
      $display("FAIL reread_hit stall_cycles=%0d mem_reqs=%0d required 0 and 0", n, acc_cnt - a0);
    end
  endtask

  task automatic test_write_merge();
    int n;
    do_write(32'h100, 4'b0011, 32'h0000CAFE, n);
    tests++;
    if (WBUF ? (n != 0) : (n == 0)) begin
      fails++;
      $display("FAIL write_stall stall_cycles=%0d required %s", n, WBUF ? "0" : "nonzero");
    end
    do_read(32'h100, n);
    tests++;
    if (bus.dcache_dout !== 32'hDEADCAFE || n != 0) begin
      fails++;
      $display("FAIL write_merge dout=%h stall_cycles=%0d required DEADCAFE hit", bus.dcache_dout, n);
    end
  endtask

  task automatic test_conflict();
    int n;
    do_read(32'h200, n);
    do_read(32'h100, n);
    tests++;
    if (n == 0 || bus.dcache_dout !== 32'hDEADCAFE) begin
      fails++;
      $display("FAIL conflict_refill stall_cycles=%0d dout=%h required miss DEADCAFE", n, bus.dcache_dout);
    end
  endtask

  task automatic test_backpressure();
    int n, pre;
    logic [29:0] w;
    mreq_t snap;
    w = 30'h048D159E;
    rdy_force_low = 1'b1;
    exp_q.push_back('{1'b1, w, 32'h0, 4'h0});
    core_req(1'b0, {w, 2'b00}, 4'h0, 32'h0, pre);
    snap = '{bus.mem_req_rnw, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask};
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (bus.stall !== 1'b1 || bus.mem_req_valid !== 1'b1 || bus.mem_req_rnw !== 1'b1 ||
          bus.mem_req_addr !== w ||
          snap !== mreq_t'{bus.mem_req_rnw, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask}) begin
        fails++;
        $display("FAIL backpressure cyc=%0d stall=%b vld=%b rnw=%b addr=%h required 1 1 1 %h",
                 k, bus.stall, bus.mem_req_valid, bus.mem_req_rnw, bus.mem_req_addr, w);
      end
      bus.dcache_addr = $urandom;
      @(negedge clk);
    end
    rdy_force_low = 1'b0;
    wait_stall_low(n);
    tests++;
    if (bus.dcache_dout !== rval(w)) begin
      fails++;
      $display("FAIL backpressure_data got=%h required=%h", bus.dcache_dout, rval(w));
    end
    mvld[w[5:0]] = 1'b1;
    mtag[w[5:0]] = w[29:6];
  endtask

`ifdef DCACHE_WBUF_EN
  task automatic test_wbuf();
    int n, pre, l0;
    l0 = acc_log.size();
    rdy_force_low = 1'b1;
    do_write(32'h10, 4'b1111, 32'h11223344, n);
    tests++;
    if (n != 0) begin fails++; $display("FAIL wbuf_write_stall got=%0d required 0", n); end
    exp_q.push_back('{1'b1, 30'h8, 32'h0, 4'h0});
    core_req(1'b0, 32'h20, 4'h0, 32'h0, pre);
    rdy_force_low = 1'b0;
    wait_stall_low(n);
    tests++;
    if (acc_log.size() != l0 + 2 || acc_log[l0].rnw !== 1'b0 || acc_log[l0].addr !== 30'h4 ||
        acc_log[l0+1].rnw !== 1'b1 || acc_log[l0+1].addr !== 30'h8) begin
      fails++;
      $display("FAIL wbuf_order reqs=%0d required write 0x4 then read 0x8", acc_log.size() - l0);
    end
    tests++;
    if (bus.dcache_dout !== rval(30'h8)) begin
      fails++;
      $display("FAIL wbuf_read_data got=%h required=%h", bus.dcache_dout, rval(30'h8));
    end
    mvld[8] = 1'b1;
    mtag[8] = 24'h0;
  endtask

  task automatic test_back_to_back();
    int n, pre, l0;
    l0 = acc_log.size();
    rdy_force_low = 1'b1;
    do_write(32'h14, 4'b0101, 32'hA5A5A5A5, n);
    rmem[30'h6] = bmerge(rval(30'h6), 32'h5A5A5A5A, 4'b1010);
    exp_q.push_back('{1'b0, 30'h6, 32'h5A5A5A5A, 4'b1010});
    core_req(1'b1, 32'h18, 4'b1010, 32'h5A5A5A5A, pre);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (bus.stall !== 1'b1 || bus.mem_req_addr !== 30'h5 || bus.mem_req_rnw !== 1'b0) begin
        fails++;
        $display("FAIL b2b_hold cyc=%0d stall=%b addr=%h required stall=1 addr=5", k, bus.stall, bus.mem_req_addr);
      end
      @(negedge clk);
    end
    rdy_force_low = 1'b0;
    wait_stall_low(n);
    repeat (20) @(negedge clk);
    tests++;
    if (acc_log.size() != l0 + 2 || acc_log[l0].addr !== 30'h5 || acc_log[l0+1].addr !== 30'h6) begin
      fails++;
      $display("FAIL b2b_order reqs=%0d required write 0x5 then 0x6", acc_log.size() - l0);
    end
  endtask
`endif

  task automatic test_random();
    int n;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = ({$urandom_range(0, 3)} << 8) | ({$urandom_range(0, 3)} << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a[31:28] = 4'($urandom);
      if ($urandom_range(0, 99) < 55) do_read(a, n);
      else do_write(a, 4'($urandom_range(1, 15)), $urandom, n);
    end
  endtask

  task automatic test_drain();
    int w0;
    w0 = 0;
    while ((exp_q.size() != 0 || bus.mem_req_valid) && w0 < TMO) begin @(negedge clk); w0++; end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain outstanding_expected=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.dcache_addr = '0; bus.dcache_we = '0; bus.dcache_re = 1'b0; bus.dcache_din = '0;
    test_reset();
    test_midmiss_reset();
    test_cold_read();
    test_write_merge();
    test_conflict();
    test_backpressure();
`ifdef DCACHE_WBUF_EN
    test_wbuf();
    test_back_to_back();
`endif
    test_random();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
